spdif_frame_scheduler: RTL and testbench

- Sequences the S/PDIF subframe encoder at one clk128 cycle per biphase half-cell, i.e. 64 cycles per subframe and 128 per frame.
- Fetches stereo samples from an upstream source through a ready/valid handshake.
- Looks up channel-status bits from an external byte store and tracks the 192-frame block.
- Delivers one 28-bit subframe word (aux/audio, V, U, C, P) plus a preamble select to the encoder with a single-cycle load strobe.

---
 rtl/spdif_frame_scheduler.sv | 106 ++++++++++
 tb/tb_spdif_frame_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spdif_frame_scheduler.sv
// spdif_frame_scheduler: steps the S/PDIF encoder through 64 half-cell slots per subframe,
// fetching stereo pairs and emitting one 28-bit subframe word plus preamble per load strobe.
module spdif_frame_scheduler #(
    parameter int SAMPLE_WIDTH = 24
) (
    input  logic                    clk128,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    input  logic [SAMPLE_WIDTH-1:0] sample_left,
    input  logic [SAMPLE_WIDTH-1:0] sample_right,
    input  logic                    sample_invalid,
    output logic [4:0]              cs_addr,
    input  logic [7:0]              cs_data,
    output logic                    load,
    output logic [1:0]              preamble_sel,
    output logic [27:0]             sub_frame_data,
    output logic [7:0]              frame_number,
    output logic                    busy,
    output logic                    underrun
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q;
    logic [5:0]  slot_q;
    logic        next_right_q;
    logic [7:0]  next_frame_q;
    logic [23:0] hold_right_q;
    logic        hold_inv_q;
    logic        load_q;
    logic        underrun_q;
    logic [1:0]  preamble_q;
    logic [27:0] word_q;
    logic [7:0]  frame_q;

    logic        boundary;
    logic [23:0] left_aligned;
    logic [23:0] right_aligned;
    logic [23:0] audio_d;
    logic        inv_d;
    logic [27:0] word_d;

    // Samples narrower than 24 bits sit MSB-aligned with zero-filled LSBs.
    assign left_aligned  = 24'(sample_left) << (24 - SAMPLE_WIDTH);
    assign right_aligned = 24'(sample_right) << (24 - SAMPLE_WIDTH);

    assign boundary     = state_q == RUN && slot_q == 6'd62;
    assign sample_ready = boundary && !next_right_q && enable;
    assign audio_d      = next_right_q ? hold_right_q : (sample_valid ? left_aligned : 24'd0);
    assign inv_d        = next_right_q ? hold_inv_q : (sample_valid ? sample_invalid : 1'b1);
    assign word_d[26:0] = {cs_data[next_frame_q[2:0]], 1'b0, inv_d, audio_d};
    assign word_d[27]   = ^word_d[26:0];

    assign cs_addr        = next_frame_q[7:3];
    assign load           = load_q;
    assign preamble_sel   = preamble_q;
    assign sub_frame_data = word_q;
    assign frame_number   = frame_q;
    assign busy           = state_q == RUN;
    assign underrun       = underrun_q;

    always_ff @(posedge clk128 or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            slot_q       <= 6'd0;
            next_right_q <= 1'b0;
            next_frame_q <= 8'd0;
            hold_right_q <= 24'd0;
            hold_inv_q   <= 1'b0;
            load_q       <= 1'b0;
            underrun_q   <= 1'b0;
            preamble_q   <= 2'd0;
            word_q       <= 28'd0;
            frame_q      <= 8'd0;
        end else begin
            load_q     <= 1'b0;
            underrun_q <= 1'b0;
            if (state_q == IDLE) begin
                if (enable) begin
                    state_q <= RUN;
                    slot_q  <= 6'd62;
                end
            end else if (boundary && !next_right_q && !enable) begin
                // Stopping only at a left boundary guarantees a complete L/R pair was sent.
                state_q <= IDLE;
            end else begin
                slot_q <= slot_q + 6'd1;
                if (boundary) begin
                    load_q       <= 1'b1;
                    word_q       <= word_d;
                    preamble_q   <= next_right_q ? 2'd2 : (next_frame_q == 8'd0 ? 2'd0 : 2'd1);
                    frame_q      <= next_frame_q;
                    next_right_q <= !next_right_q;
                    if (next_right_q) begin
                        next_frame_q <= next_frame_q == 8'd191 ? 8'd0 : next_frame_q + 8'd1;
                    end else begin
                        hold_right_q <= sample_valid ? right_aligned : 24'd0;
                        hold_inv_q   <= inv_d;
                        underrun_q   <= !sample_valid;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spdif_frame_scheduler.sv
// tb_spdif_frame_scheduler: scenario tasks checked against a frame-level model of the
// scheduler (load times, fetch times, word contents) kept in the bench.
module tb_spdif_frame_scheduler;
    logic        clk128 = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic        sample_invalid = 1'b0;
    logic [23:0] sample_left = '0;
    logic [23:0] sample_right = '0;
    logic [7:0]  cs_mem [24];

    logic        sample_ready, load, busy, underrun;
    logic [4:0]  cs_addr;
    logic [7:0]  cs_data, frame_number;
    logic [1:0]  preamble_sel;
    logic [27:0] sub_frame_data;

    logic        sample_ready16, load16, busy16, underrun16;
    logic [4:0]  cs_addr16;
    logic [7:0]  cs_data16, frame_number16;
    logic [1:0]  preamble_sel16;
    logic [27:0] sub_frame_data16;

    assign cs_data   = cs_addr < 5'd24 ? cs_mem[cs_addr] : 8'h00;
    assign cs_data16 = cs_addr16 < 5'd24 ? cs_mem[cs_addr16] : 8'h00;

    spdif_frame_scheduler #(.SAMPLE_WIDTH(24)) dut (
        .clk128(clk128), .reset(reset), .enable(enable), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .sample_left(sample_left), .sample_right(sample_right),
        .sample_invalid(sample_invalid), .cs_addr(cs_addr), .cs_data(cs_data), .load(load),
        .preamble_sel(preamble_sel), .sub_frame_data(sub_frame_data),
        .frame_number(frame_number), .busy(busy), .underrun(underrun)
    );

    spdif_frame_scheduler #(.SAMPLE_WIDTH(16)) dut16 (
        .clk128(clk128), .reset(reset), .enable(enable), .sample_valid(sample_valid),
        .sample_ready(sample_ready16), .sample_left(sample_left[15:0]),
        .sample_right(sample_right[15:0]), .sample_invalid(sample_invalid),
        .cs_addr(cs_addr16), .cs_data(cs_data16), .load(load16),
        .preamble_sel(preamble_sel16), .sub_frame_data(sub_frame_data16),
        .frame_number(frame_number16), .busy(busy16), .underrun(underrun16)
    );

    always #5 clk128 = ~clk128;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int obs_cyc = 0;
    logic obs_ready;

    // Model: a running link loads every 64 cycles; the cycle before a left load is the fetch.
    bit          m_run, m_right, exp_ready, exp_load;
    int          m_next_load, m_frame;
    logic [23:0] m_hold_r;
    logic        m_hold_inv;
    logic [23:0] e_audio;
    logic        e_inv, e_under;
    logic [1:0]  e_pre;
    int          e_frame;
    logic [27:0] e_word;

    task automatic model_reset();
        m_run = 0; m_right = 0; m_frame = 0; m_hold_r = '0; m_hold_inv = 0; exp_load = 0;
    endtask

    task automatic tick();
        bit nxt = 0;
        #1;
        obs_ready = sample_ready;
        obs_cyc = cyc;
        exp_ready = 0;
        if (m_run && cyc + 1 == m_next_load) begin
            if (!m_right && !enable) m_run = 0;
            else begin
                nxt = 1;
                exp_ready = !m_right;
                if (!m_right) begin
                    e_audio = sample_valid ? sample_left : 24'd0;
                    e_inv = sample_valid ? sample_invalid : 1'b1;
                    e_under = !sample_valid;
                    m_hold_r = sample_valid ? sample_right : 24'd0;
                    m_hold_inv = e_inv;
                end else begin
                    e_audio = m_hold_r; e_inv = m_hold_inv; e_under = 0;
                end
                e_pre = m_right ? 2'd2 : (m_frame == 0 ? 2'd0 : 2'd1);
                e_frame = m_frame;
                e_word = {1'b0, cs_mem[m_frame / 8][m_frame % 8], 1'b0, e_inv, e_audio};
                e_word[27] = ^e_word[26:0];
                if (m_right) m_frame = (m_frame + 1) % 192;
                m_right = !m_right;
                m_next_load = cyc + 65;
            end
        end else if (!m_run && enable) begin
            m_run = 1;
            m_next_load = cyc + 2;
        end
        @(posedge clk128);
        #1;
        cyc++;
        exp_load = nxt;
    endtask

    task automatic goto_fetch();
        int n = 0;
        while (!(m_run && m_next_load == cyc + 1 && !m_right) && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL goto_fetch: waited %0d cycles, required a fetch slot within 300", n);
        end
    endtask

    task automatic test_reset();
        reset = 1; enable = 0;
        repeat (3) @(posedge clk128);
        #1;
        checks += 9;
        if (load !== 1'b0) begin errors++; $display("FAIL rst_load: got %b required 0", load); end
        if (sample_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", sample_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
        if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %b required 0", underrun); end
        if (preamble_sel !== 2'd0) begin errors++; $display("FAIL rst_pre: got %0d required 0", preamble_sel); end
        if (sub_frame_data !== 28'd0) begin errors++; $display("FAIL rst_data: got %h required 0", sub_frame_data); end
        if (frame_number !== 8'd0) begin errors++; $display("FAIL rst_frame: got %0d required 0", frame_number); end
        if (cs_addr !== 5'd0) begin errors++; $display("FAIL rst_cs_addr: got %0d required 0", cs_addr); end
        if (load16 !== 1'b0) begin errors++; $display("FAIL rst_load16: got %b required 0", load16); end
        reset = 0;
        model_reset();
    endtask

    task automatic test_startup();
        int k;
        sample_valid = 1; sample_invalid = 0;
        sample_left = 24'h123456; sample_right = 24'hABCDEF;
        repeat (5) tick();
        k = cyc;
        enable = 1;
        for (int i = 0; i < 68; i++) begin
            tick();
            checks += 2;
            if (obs_ready !== (obs_cyc == k + 1)) begin
                errors++; $display("FAIL start_ready: cycle +%0d got %b", obs_cyc - k, obs_ready);
            end
            if (load !== (cyc == k + 2 || cyc == k + 66)) begin
                errors++; $display("FAIL start_load: cycle +%0d got %b", cyc - k, load);
            end
            if (cyc == k + 2) begin
                checks += 3;
                if (sub_frame_data !== 28'h8123456) begin errors++; $display("FAIL start_left_word: got %h required 8123456", sub_frame_data); end
                if (preamble_sel !== 2'd0) begin errors++; $display("FAIL start_left_pre: got %0d required 0", preamble_sel); end
                if (frame_number !== 8'd0) begin errors++; $display("FAIL start_frame: got %0d required 0", frame_number); end
            end
            if (cyc == k + 66) begin
                checks += 2;
                if (sub_frame_data !== 28'h8ABCDEF) begin errors++; $display("FAIL start_right_word: got %h required 8abcdef", sub_frame_data); end
                if (preamble_sel !== 2'd2) begin errors++; $display("FAIL start_right_pre: got %0d required 2", preamble_sel); end
            end
        end
    endtask

    task automatic test_underrun();
        logic [23:0] l;
        goto_fetch();
        sample_valid = 0;
        tick();
        checks += 4;
        if (obs_ready !== 1'b1) begin errors++; $display("FAIL ur_ready: got %b required 1", obs_ready); end
        if (load !== 1'b1) begin errors++; $display("FAIL ur_load: got %b required 1", load); end
        if (underrun !== 1'b1) begin errors++; $display("FAIL ur_pulse: got %b required 1", underrun); end
        if (sub_frame_data[24:0] !== 25'h1000000) begin errors++; $display("FAIL ur_left_word: got %h required V=1 audio 0", sub_frame_data[24:0]); end
        sample_valid = 1; sample_invalid = 0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            checks++;
            if (underrun !== 1'b0) begin errors++; $display("FAIL ur_no_second: cycle +%0d got %b required 0", i, underrun); end
        end
        checks += 2;
        if (load !== 1'b1) begin errors++; $display("FAIL ur_right_load: got %b required 1", load); end
        if (sub_frame_data[24:0] !== 25'h1000000) begin errors++; $display("FAIL ur_right_word: got %h required V=1 audio 0", sub_frame_data[24:0]); end
        goto_fetch();
        l = 24'($urandom());
        sample_left = l;
        tick();
        checks += 3;
        if (underrun !== 1'b0) begin errors++; $display("FAIL ur_recover_pulse: got %b required 0", underrun); end
        if (sub_frame_data[24] !== 1'b0) begin errors++; $display("FAIL ur_recover_v: got %b required 0", sub_frame_data[24]); end
        if (sub_frame_data[23:0] !== l) begin errors++; $display("FAIL ur_recover_audio: got %h required %h", sub_frame_data[23:0], l); end
    endtask

    task automatic test_width16();
        goto_fetch();
        sample_left = 24'h008001; sample_valid = 1;
        tick();
        checks += 4;
        if (load16 !== 1'b1) begin errors++; $display("FAIL w16_load: got %b required 1", load16); end
        if (sub_frame_data16[23:0] !== 24'h800100) begin errors++; $display("FAIL w16_audio: got %h required 800100", sub_frame_data16[23:0]); end
        if ((^sub_frame_data16) !== 1'b0) begin errors++; $display("FAIL w16_parity: got odd word %h required even", sub_frame_data16); end
        if (sub_frame_data[23:0] !== 24'h008001) begin errors++; $display("FAIL w24_audio: got %h required 008001", sub_frame_data[23:0]); end
    endtask

    task automatic test_disable();
        int l0;
        goto_fetch();
        tick();
        l0 = cyc;
        repeat (20) tick();
        enable = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            checks += 2;
            if (load !== (cyc == l0 + 64)) begin errors++; $display("FAIL dis_load: cycle +%0d got %b", cyc - l0, load); end
            if (busy !== (cyc < l0 + 128)) begin errors++; $display("FAIL dis_busy: cycle +%0d got %b", cyc - l0, busy); end
            if (obs_cyc == l0 + 127) begin
                checks++;
                if (obs_ready !== 1'b0) begin errors++; $display("FAIL dis_ready: got %b required 0", obs_ready); end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        enable = 1;
        goto_fetch();
        tick();
        repeat (31) tick();
        reset = 1;
        #1;
        checks += 8;
        if (load !== 1'b0) begin errors++; $display("FAIL mid_load: got %b required 0", load); end
        if (sample_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b required 0", sample_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b required 0", busy); end
        if (underrun !== 1'b0) begin errors++; $display("FAIL mid_underrun: got %b required 0", underrun); end
        if (preamble_sel !== 2'd0) begin errors++; $display("FAIL mid_pre: got %0d required 0", preamble_sel); end
        if (sub_frame_data !== 28'd0) begin errors++; $display("FAIL mid_data: got %h required 0", sub_frame_data); end
        if (frame_number !== 8'd0) begin errors++; $display("FAIL mid_frame: got %0d required 0", frame_number); end
        if (cs_addr !== 5'd0) begin errors++; $display("FAIL mid_cs_addr: got %0d required 0", cs_addr); end
        #1;
        reset = 0;
        model_reset();
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = load;
        end
        checks += 3;
        if (!found) begin errors++; $display("FAIL mid_restart: got no load required one within 10 cycles"); end
        if (frame_number !== 8'd0) begin errors++; $display("FAIL mid_restart_frame: got %0d required 0", frame_number); end
        if (preamble_sel !== 2'd0) begin errors++; $display("FAIL mid_restart_pre: got %0d required 0", preamble_sel); end
    endtask

    task automatic test_channel_status();
        reset = 1;
        #2;
        reset = 0;
        model_reset();
        for (int i = 0; i < 24; i++) cs_mem[i] = 8'h00;
        cs_mem[0] = 8'h01; cs_mem[1] = 8'h80;
        enable = 1; sample_valid = 1;
        for (int i = 0; i < 17 * 128 + 8; i++) begin
            tick();
            if (load) begin
                checks++;
                if (sub_frame_data[26] !== (frame_number == 0 || frame_number == 15)) begin
                    errors++; $display("FAIL cs_c: frame %0d pre %0d got %b", frame_number, preamble_sel, sub_frame_data[26]);
                end
                if (preamble_sel != 2'd2) begin
                    checks++;
                    if (cs_addr !== 5'(frame_number / 8)) begin errors++; $display("FAIL cs_addr: frame %0d got %0d", frame_number, cs_addr); end
                end
            end
        end
    endtask

    task automatic test_stream();
        int b_first = -1, b_count = 0;
        reset = 1;
        #2;
        reset = 0;
        model_reset();
        for (int i = 0; i < 24; i++) cs_mem[i] = 8'($urandom());
        enable = 1;
        for (int i = 0; i < 193 * 128 + 200; i++) begin
            sample_left = 24'($urandom()); sample_right = 24'($urandom());
            sample_invalid = $urandom_range(7) == 0;
            sample_valid = $urandom_range(11) != 0;
            tick();
            checks += 4;
            if (obs_ready !== exp_ready) begin errors++; $display("FAIL st_ready: cycle %0d got %b required %b", obs_cyc, obs_ready, exp_ready); end
            if (load !== exp_load) begin errors++; $display("FAIL st_load: cycle %0d got %b required %b", cyc, load, exp_load); end
            if (busy !== m_run) begin errors++; $display("FAIL st_busy: cycle %0d got %b required %b", cyc, busy, m_run); end
            if (cs_addr !== 5'(m_frame / 8)) begin errors++; $display("FAIL st_cs_addr: cycle %0d got %0d required %0d", cyc, cs_addr, m_frame / 8); end
            if (exp_load) begin
                checks += 4;
                if (sub_frame_data !== e_word) begin errors++; $display("FAIL st_word: frame %0d got %h required %h", e_frame, sub_frame_data, e_word); end
                if (preamble_sel !== e_pre) begin errors++; $display("FAIL st_pre: frame %0d got %0d required %0d", e_frame, preamble_sel, e_pre); end
                if (frame_number !== 8'(e_frame)) begin errors++; $display("FAIL st_frame: got %0d required %0d", frame_number, e_frame); end
                if (underrun !== e_under) begin errors++; $display("FAIL st_underrun: frame %0d got %b required %b", e_frame, underrun, e_under); end
                if (e_frame == 191 && e_pre != 2'd2) begin
                    checks++;
                    if (preamble_sel !== 2'd1) begin errors++; $display("FAIL st_f191_pre: got %0d required 1", preamble_sel); end
                end
                if (e_pre == 2'd0) begin
                    if (b_count == 1) begin
                        checks++;
                        if (cyc - b_first !== 192 * 128) begin errors++; $display("FAIL st_block_period: got %0d required %0d", cyc - b_first, 192 * 128); end
                    end
                    if (b_count == 0) b_first = cyc;
                    b_count++;
                end
            end else begin
                checks++;
                if (underrun !== 1'b0) begin errors++; $display("FAIL st_underrun_idle: cycle %0d got %b required 0", cyc, underrun); end
            end
        end
        checks++;
        if (b_count < 2) begin errors++; $display("FAIL st_block_wrap: got %0d B loads required 2", b_count); end
    endtask

    initial begin
        for (int i = 0; i < 24; i++) cs_mem[i] = 8'h00;
        model_reset();
        test_reset();
        test_startup();
        test_underrun();
        test_width16();
        test_disable();
        test_reset_mid();
        test_channel_status();
        test_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
